// File: rtl/mem_pkg.sv
// Shared types and constants for the cache-fill memory responder.
// Word width and block size match the cache's 16-byte block of 16-bit words.
package mem_pkg;

    localparam int WORD_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int DEF_LATENCY = 4;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
    } pipe_stage_t;

endpackage

// File: rtl/mem_lat_pipe.sv
// LATENCY-deep {valid, data} shift register carrying read returns.
// Valid bits clear asynchronously; busy is the OR of all stage valids.
module mem_lat_pipe
    import mem_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  pipe_stage_t       in_stage,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              busy
);

    pipe_stage_t stage_q [LATENCY];
    pipe_stage_t stage_d [LATENCY];
    pipe_stage_t chain   [LATENCY];

    // Data only moves with a valid word, so the last stage holds the most recent return.
    always_comb begin
        chain[0] = in_stage;
        for (int i = 1; i < LATENCY; i++) begin
            chain[i] = stage_q[i-1];
        end
        for (int i = 0; i < LATENCY; i++) begin
            stage_d[i].valid = chain[i].valid;
            stage_d[i].data  = chain[i].valid ? chain[i].data : stage_q[i].data;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | stage_q[i].valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift off the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_valid = stage_q[LATENCY-1].valid;
    assign out_data  = stage_q[LATENCY-1].data;

endmodule

// File: rtl/mem_fill_responder.sv
// Word-addressed memory answering cache fills with a fixed read latency.
// The array starts zeroed at time zero; INIT_FILE is retained as a parameter only.
module mem_fill_responder
    import mem_pkg::*;
#(
    parameter int LATENCY   = DEF_LATENCY,
    parameter int WORD_AW   = 15,
    parameter     INIT_FILE = "mem.hex"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** WORD_AW;

    mem_req_t           req;
    logic [WORD_AW-1:0] word_addr;
    pipe_stage_t        capture;
    logic               unused_byte_sel;

    // NOTE: the array has no reset; only the pipeline valid bits are cleared by rst.
    logic [WORD_W-1:0] mem_array [DEPTH];

    localparam int unused_init_len = $bits(INIT_FILE);

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_array[i] = '0;
        end
    end

    assign req             = '{wr: wr, addr: addr, data: data_in};
    assign word_addr       = req.addr[WORD_AW:1];
    assign unused_byte_sel = req.addr[0];

    // A write landing on the same edge as an asserted reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && enable && req.wr) begin
            mem_array[word_addr] <= req.data;
        end
    end

    // Reads capture the pre-edge array word, so later writes cannot disturb them.
    always_comb begin
        capture       = '0;
        capture.valid = enable & ~req.wr;
        capture.data  = mem_array[word_addr];
    end

    mem_lat_pipe #(
        .LATENCY (LATENCY)
    ) u_lat_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_stage  (capture),
        .out_valid (data_valid),
        .out_data  (data_out),
        .busy      (busy)
    );

endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed self-checking bench for mem_fill_responder (LATENCY=4, zero-initialised array).
module tb_mem_fill_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mem_fill_responder dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic edv, input logic eb, input logic [15:0] ed);
        chk({tag, ".valid"}, {15'd0, data_valid}, {15'd0, edv});
        chk({tag, ".busy"},  {15'd0, busy},       {15'd0, eb});
        chk({tag, ".data"},  data_out,            ed);
    endtask

    // Check this cycle's outputs, drive this cycle's request, advance to just after the next edge.
    task automatic cyc(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic edv, input logic eb, input logic [15:0] ed, input string tag);
        chk_out(tag, edv, eb, ed);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ed;

        rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        @(posedge clk); @(posedge clk); #1;
        chk_out("reset", 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;

        // Preload through the write port.
        cyc(1, 1, 16'h0040, 16'hBEEF, 0, 0, 16'h0000, "pre_beef");
        cyc(1, 1, 16'h0200, 16'h0001, 0, 0, 16'h0000, "pre_0200");
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 16'h1230 + 16'(2 * i), 16'hC000 + 16'(i), 0, 0, 16'h0000, "pre_blk");
        end

        // Single read.
        cyc(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0000, "single_c0");
        for (int k = 1; k < 4; k++) cyc(0, 0, 16'h0, 16'h0, 0, 1, 16'h0000, "single_wait");
        cyc(0, 0, 16'h0, 16'h0, 1, 1, 16'hBEEF, "single_c4");
        cyc(0, 0, 16'h0, 16'h0, 0, 0, 16'hBEEF, "single_c5");

        // Block fill: 8 back-to-back reads.
        for (int k = 0; k < 13; k++) begin
            if (k < 4)       ed = 16'hBEEF;
            else if (k < 12) ed = 16'hC000 + 16'(k - 4);
            else             ed = 16'hC007;
            cyc(k < 8, 0, 16'h1230 + 16'(2 * k), 16'h0, (k >= 4) && (k < 12),
                (k >= 1) && (k < 12), ed, "block");
        end

        // Write then read next cycle.
        cyc(1, 1, 16'h0100, 16'h1234, 0, 0, 16'hC007, "wtr_c0");
        cyc(1, 0, 16'h0100, 16'h0,    0, 0, 16'hC007, "wtr_c1");
        for (int k = 2; k < 5; k++) cyc(0, 0, 16'h0, 16'h0, 0, 1, 16'hC007, "wtr_wait");
        cyc(0, 0, 16'h0, 16'h0, 1, 1, 16'h1234, "wtr_c5");
        cyc(0, 0, 16'h0, 16'h0, 0, 0, 16'h1234, "wtr_c6");

        // Read shadowed by a later write.
        cyc(1, 0, 16'h0200, 16'h0,    0, 0, 16'h1234, "shadow_c0");
        cyc(1, 1, 16'h0200, 16'hAAAA, 0, 1, 16'h1234, "shadow_c1");
        cyc(1, 0, 16'h0200, 16'h0,    0, 1, 16'h1234, "shadow_c2");
        cyc(0, 0, 16'h0,    16'h0,    0, 1, 16'h1234, "shadow_c3");
        cyc(0, 0, 16'h0,    16'h0,    1, 1, 16'h0001, "shadow_c4");
        cyc(0, 0, 16'h0,    16'h0,    0, 1, 16'h0001, "shadow_c5");
        cyc(0, 0, 16'h0,    16'h0,    1, 1, 16'hAAAA, "shadow_c6");
        cyc(0, 0, 16'h0,    16'h0,    0, 0, 16'hAAAA, "shadow_c7");

        // Reset mid-flight, with a write held during reset and a read on release.
        cyc(1, 0, 16'h1230, 16'h0, 0, 0, 16'hAAAA, "rst_c0");
        cyc(1, 0, 16'h1232, 16'h0, 0, 1, 16'hAAAA, "rst_c1");
        cyc(1, 0, 16'h1234, 16'h0, 0, 1, 16'hAAAA, "rst_c2");
        chk_out("rst_c3", 1'b0, 1'b1, 16'hAAAA);
        enable = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk_out("rst_drop", 1'b0, 1'b0, 16'h0000);
        enable = 1'b1; wr = 1'b1; addr = 16'h0040; data_in = 16'hDEAD;
        @(posedge clk); #1;
        chk_out("rst_hold", 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
        cyc(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0000, "rel_c0");
        for (int k = 1; k < 4; k++) cyc(0, 0, 16'h0, 16'h0, 0, 1, 16'h0000, "rel_wait");
        cyc(0, 0, 16'h0, 16'h0, 1, 1, 16'hBEEF, "rel_c4");
        cyc(0, 0, 16'h0, 16'h0, 0, 0, 16'hBEEF, "rel_c5");

        // Gapped requests.
        cyc(1, 0, 16'h1230, 16'h0, 0, 0, 16'hBEEF, "gap_c0");
        cyc(0, 0, 16'h0,    16'h0, 0, 1, 16'hBEEF, "gap_c1");
        cyc(1, 0, 16'h1232, 16'h0, 0, 1, 16'hBEEF, "gap_c2");
        cyc(0, 0, 16'h0,    16'h0, 0, 1, 16'hBEEF, "gap_c3");
        cyc(0, 0, 16'h0,    16'h0, 1, 1, 16'hC000, "gap_c4");
        cyc(0, 0, 16'h0,    16'h0, 0, 1, 16'hC000, "gap_c5");
        cyc(0, 0, 16'h0,    16'h0, 1, 1, 16'hC001, "gap_c6");
        cyc(0, 0, 16'h0,    16'h0, 0, 0, 16'hC001, "gap_c7");

        // Byte bit 0 ignored at the top of the address space.
        cyc(1, 1, 16'hFFFF, 16'h5A5A, 0, 0, 16'hC001, "wrap_c0");
        cyc(1, 0, 16'hFFFE, 16'h0,    0, 0, 16'hC001, "wrap_c1");
        cyc(1, 0, 16'hFFFF, 16'h0,    0, 1, 16'hC001, "wrap_c2");
        cyc(0, 0, 16'h0,    16'h0,    0, 1, 16'hC001, "wrap_c3");
        cyc(0, 0, 16'h0,    16'h0,    0, 1, 16'hC001, "wrap_c4");
        cyc(0, 0, 16'h0,    16'h0,    1, 1, 16'h5A5A, "wrap_c5");
        cyc(0, 0, 16'h0,    16'h0,    1, 1, 16'h5A5A, "wrap_c6");
        cyc(0, 0, 16'h0,    16'h0,    0, 0, 16'h5A5A, "wrap_c7");

        // Unwritten word reads back as zero.
        cyc(1, 0, 16'h0002, 16'h0, 0, 0, 16'h5A5A, "zero_c0");
        for (int k = 1; k < 4; k++) cyc(0, 0, 16'h0, 16'h0, 0, 1, 16'h5A5A, "zero_wait");
        cyc(0, 0, 16'h0, 16'h0, 1, 1, 16'h0000, "zero_c4");
        chk_out("zero_c5", 1'b0, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_fill_responder.md
Name: mem_fill_responder

Overview:
- Main-memory side of the cache fill interface. It answers cache-fill reads and write-through writes issued by the cache fill FSM.
- Pipelined, word-addressed memory with a fixed read latency of LATENCY cycles and one request accepted per cycle.
- Returns read data with a single-cycle valid strobe that drives the cache's mem_data_valid/mem_data inputs.
- One instance serves one cache, either I-cache or D-cache.

Parameters:
- LATENCY, 4, cycles from read request to data_valid; legal range 1..8.
- WORD_AW, 15, word-address bits; the array holds 2^WORD_AW 16-bit words.
- INIT_FILE, "mem.hex", hex image loaded when preload is compiled in.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  request strobe; one request per cycle while high.
- wr  in  1  1 = write request, 0 = read request; sampled only when enable=1.
- addr  in  16  byte address; bits [WORD_AW:1] select the word, bit 0 is ignored.
- data_in  in  16  write data.
- data_out  out  16  read data; meaningful only while data_valid=1.
- data_valid  out  1  one-cycle strobe that returns a read.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset (asynchronous): every pipeline-stage valid bit clears, data_valid=0, data_out=16'h0000, busy=0. Array contents are not cleared by reset.
- Write (enable=1, wr=1): the array word is updated at the same clock edge. No response strobe is produced. The request never enters the read pipeline.
- Read (enable=1, wr=0): the array word is sampled at the request edge and placed in pipeline stage 1 with valid=1. It advances one stage per cycle.
- Read timing: a read requested in cycle T drives data_valid=1 and data_out in cycle T+LATENCY, for exactly one cycle.
- Pipelining: back-to-back reads are fully pipelined. N consecutive reads produce N consecutive data_valid cycles, in request order. There is no backpressure and no ready signal; the requester must always accept returns.
- Read/write ordering: data is captured at request time. A write to the same word issued after a read (even on the next cycle) does not affect that in-flight read.
- enable=0: nothing enters the pipeline, and the stage-1 valid bit clears. Gaps in requests therefore appear as gaps in the data_valid strobes.
- data_out between strobes: holds the last returned value. It is not required to be X-free only before the first strobe after power-up without reset.
- busy: OR of all stage valid bits, combinational.
- Address boundary: addresses wrap modulo the 2^WORD_AW word array. Address 16'hFFFF maps to the same word as 16'hFFFE.
- Reset mid-operation: all in-flight reads are discarded and no data_valid is produced for them. A write coinciding with reset assertion is not committed.
- Same-cycle rst deassertion and enable: the request is accepted on the first rising edge where rst=0.

Optional Feature:
- Macro: MEM_PRELOAD_EN.
- Defined: the array is initialised at time zero from INIT_FILE using hex word format.
- Undefined: the array is initialised to all zeros at time zero, and INIT_FILE is unused.
- Neither mode changes reset or timing behaviour.

Decomposition:
- Shared package mem_pkg holds:
  - WORD_W=16 and BLOCK_WORDS=8, matching the cache's 16-byte block;
  - the default LATENCY=4;
  - the mem_req_t packing {wr, addr, data_in}.
- One sub-module: mem_lat_pipe. It is a LATENCY-deep shift register carrying {valid, data[15:0]}, with asynchronous clear of the valid bits and a combinational busy OR-reduce.
- The top level holds the array, the write path and the pipeline-stage-1 capture.

Test Plan:
- Single read: preload word at 16'h0040 = 16'hBEEF; read issued at cycle 0 -> data_valid=1 only at cycle 4 with data_out=16'hBEEF; busy high in cycles 1-4.
- Block fill: 8 consecutive reads of 16'h1230, 16'h1232 … 16'h123E -> data_valid high in cycles 4-11; data matches in address order; no gaps.
- Write-then-read: write 16'h1234 to 16'h0100 at cycle 0; read 16'h0100 at cycle 1 -> 16'h1234 returned at cycle 5; no strobe is caused by the write.
- Read shadowed by a later write: read 16'h0200 (old value 16'h0001) at cycle 0; write 16'hAAAA to 16'h0200 at cycle 1 -> cycle 4 returns 16'h0001; a read at cycle 2 returns 16'hAAAA at cycle 6.
- Reset mid-flight: reads at cycles 0-2; rst pulsed in cycle 3 between clock edges -> data_valid and busy drop immediately and no strobes follow; a new read after release returns correctly after 4 cycles.
- Gapped requests and wrap: reads at cycles 0 and 2 with enable=0 at cycle 1 -> strobes at cycles 4 and 6 only. A read at 16'hFFFF returns the same word as 16'hFFFE.
